dsp_pipe_reg: RTL and testbench

DSP_PIPE_REG -- requirements
Module: dsp_pipe_reg

---
 rtl/dsp_pipe_pkg.sv | 19 +
 rtl/dsp_pipe_stage.sv | 29 ++
 rtl/dsp_pipe_reg.sv | 85 ++++++++
 tb/tb_dsp_pipe_reg.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pipe_pkg.sv
// Shared constants and the tap-select width helper for the DSP pipeline register.
package dsp_pipe_pkg;

    localparam int unsigned MAX_DEPTH  = 8;
    localparam int unsigned TAP_BYPASS = 0;

    // Bits needed to encode values 0..value-1; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/dsp_pipe_stage.sv
// One pipeline stage: data plus valid register with clock enable and synchronous clear.
module dsp_pipe_stage #(
    parameter int unsigned W = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         sclr,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic [W-1:0] out_data,
    output logic         out_valid
);

    // sclr wins over ce; data advances regardless of the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (sclr) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (ce) begin
            out_data  <= in_data;
            out_valid <= in_valid;
        end
    end

endmodule

// File: rtl/dsp_pipe_reg.sv
// Configurable-depth DSP pipeline register with width extension, selectable output tap
// and a live count of valid stages.
module dsp_pipe_reg
    import dsp_pipe_pkg::*;
#(
    parameter int unsigned IN_W   = 18,
    parameter int unsigned OUT_W  = 18,
    parameter int unsigned DEPTH  = 2,
    parameter bit          SIGNED = 1'b1,
    localparam int unsigned TW    = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              sclr,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    input  logic [TW-1:0]     tap_sel,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    output logic [TW-1:0]     occupancy,
    output logic              tap_err
);

    if (OUT_W < IN_W) begin : g_bad_width
        $error("dsp_pipe_reg: OUT_W (%0d) must not be smaller than IN_W (%0d)", OUT_W, IN_W);
    end
    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $error("dsp_pipe_reg: DEPTH (%0d) must be within 1..%0d", DEPTH, MAX_DEPTH);
    end

    logic [OUT_W-1:0] ext_data;
    logic [OUT_W-1:0] st_data [DEPTH+1];
    logic [DEPTH:0]   st_valid;
    int unsigned      sel;

    always_comb begin
        if (SIGNED) begin
            ext_data = OUT_W'($signed(in_data));
        end else begin
            ext_data = OUT_W'(in_data);
        end
    end

    // Index 0 of the stage arrays is the unregistered input, so the tap mux treats bypass uniformly.
    assign st_data[TAP_BYPASS]  = ext_data;
    assign st_valid[TAP_BYPASS] = in_valid;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        dsp_pipe_stage #(
            .W (OUT_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .ce        (ce),
            .sclr      (sclr),
            .in_data   (st_data[k-1]),
            .in_valid  (st_valid[k-1]),
            .out_data  (st_data[k]),
            .out_valid (st_valid[k])
        );
    end

    // Out-of-range selects fall back to the last stage and raise tap_err.
    always_comb begin
        sel       = 32'(tap_sel);
        tap_err   = (sel > DEPTH);
        out_data  = st_data[DEPTH];
        out_valid = st_valid[DEPTH];
        for (int unsigned i = 0; i <= DEPTH; i++) begin
            if (sel == i) begin
                out_data  = st_data[i];
                out_valid = st_valid[i];
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 1; i <= DEPTH; i++) begin
            occupancy = occupancy + TW'(st_valid[i]);
        end
    end

endmodule

// File: tb/tb_dsp_pipe_reg.sv
// Scoreboard bench for dsp_pipe_reg: two 48-bit DEPTH=3 instances (signed/unsigned) and
// one 18-bit DEPTH=2 instance share the input stream.
module tb_dsp_pipe_reg;

    typedef struct packed {
        logic [47:0] s;
        logic [47:0] u;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        sclr;
    logic [17:0] in_data;
    logic        in_valid;

    logic [1:0]  tap_sel_a, tap_sel_b, tap_sel_c;
    logic [47:0] out_data_a, out_data_b;
    logic [17:0] out_data_c;
    logic        out_valid_a, out_valid_b, out_valid_c;
    logic [1:0]  occ_a, occ_b, occ_c;
    logic        tap_err_a, tap_err_b, tap_err_c;

    int   total  = 0;
    int   bad    = 0;
    bit   mon_en = 1'b0;
    bit   adv    = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    dsp_pipe_reg #(.IN_W(18), .OUT_W(48), .DEPTH(3), .SIGNED(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_data(in_data), .in_valid(in_valid),
        .tap_sel(tap_sel_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .occupancy(occ_a), .tap_err(tap_err_a)
    );

    dsp_pipe_reg #(.IN_W(18), .OUT_W(48), .DEPTH(3), .SIGNED(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_data(in_data), .in_valid(in_valid),
        .tap_sel(tap_sel_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .occupancy(occ_b), .tap_err(tap_err_b)
    );

    dsp_pipe_reg #(.IN_W(18), .OUT_W(18), .DEPTH(2), .SIGNED(1'b1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .ce(ce), .sclr(sclr), .in_data(in_data), .in_valid(in_valid),
        .tap_sel(tap_sel_c), .out_data(out_data_c), .out_valid(out_valid_c),
        .occupancy(occ_c), .tap_err(tap_err_c)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [17:0] d, input logic v,
                         input logic [47:0] es, input logic [47:0] eu);
        in_data  = d;
        in_valid = v;
        ce       = 1'b1;
        sclr     = 1'b0;
        if (v) sb.push_back('{s: es, u: eu});
        step();
    endtask

    // Monitor: pops one expectation per new valid sample leaving stage 3.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            adv = rst_n && ce && !sclr;
            @(negedge clk);
            if (mon_en && adv && tap_sel_a == 2'd3 && out_valid_a) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got data %h with no expectation queued", out_data_a);
                end else begin
                    e = sb.pop_front();
                    chk("sb_signed", out_data_a, e.s);
                    chk("sb_unsigned", out_data_b, e.u);
                    chk("sb_valid_b", out_valid_b, 1);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0; ce = 1'b0; sclr = 1'b0; in_valid = 1'b0; in_data = '0;
        tap_sel_a = 2'd3; tap_sel_b = 2'd3; tap_sel_c = 2'd2;

        // Reset state and bypass during reset
        #22;
        chk("rst_occ", occ_a, 0);
        chk("rst_valid_tap3", out_valid_a, 0);
        chk("rst_data_tap3", out_data_a, 0);
        chk("rst_occ_c", occ_c, 0);
        tap_sel_a = 2'd0; in_data = 18'h00005; in_valid = 1'b1;
        #1;
        chk("rst_bypass_data", out_data_a, 48'h5);
        chk("rst_bypass_valid", out_valid_a, 1);
        tap_sel_a = 2'd3; in_valid = 1'b0; in_data = '0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step();
        chk("post_rst_occ", occ_a, 0);

        // Fill: latency 3 and occupancy ramp
        issue(18'h20000, 1'b1, 48'hFFFF_FFFE_0000, 48'h0000_0002_0000);
        chk("fill_occ1", occ_a, 1);
        chk("fill_valid1", out_valid_a, 0);
        issue(18'h00005, 1'b1, 48'h0000_0000_0005, 48'h0000_0000_0005);
        chk("fill_occ2", occ_a, 2);
        chk("fill_valid2", out_valid_a, 0);
        issue(18'h3FFFF, 1'b1, 48'hFFFF_FFFF_FFFF, 48'h0000_0003_FFFF);
        chk("fill_occ3", occ_a, 3);
        issue(18'h1ABCD, 1'b1, 48'h0000_0001_ABCD, 48'h0000_0001_ABCD);
        chk("full_occ", occ_a, 3);

        // Clock-enable freeze with a would-be sample on the input
        ce = 1'b0; in_data = 18'h11111; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("freeze_occ", occ_a, 3);
            chk("freeze_data_a", out_data_a, 48'h5);
            chk("freeze_data_b", out_data_b, 48'h5);
        end
        issue(18'h2A5A5, 1'b1, 48'hFFFF_FFFE_A5A5, 48'h0000_0002_A5A5);
        issue(18'h00123, 1'b0, '0, '0);
        issue(18'h3FF00, 1'b0, '0, '0);
        ce = 1'b0; in_valid = 1'b0;
        chk("bubble_occ", occ_a, 1);
        @(negedge clk);
        #1;
        chk("sb_drained1", sb.size(), 0);

        // Bypass and live tap switching; bubbles carry data
        tap_sel_a = 2'd0; in_data = 18'h00005; in_valid = 1'b1;
        #1;
        chk("bypass_data", out_data_a, 48'h5);
        chk("bypass_valid", out_valid_a, 1);
        tap_sel_a = 2'd2;
        #1;
        chk("tap2_data", out_data_a, 48'h0000_0000_0123);
        chk("tap2_valid", out_valid_a, 0);
        tap_sel_a = 2'd1;
        #1;
        chk("tap1_data", out_data_a, 48'hFFFF_FFFF_FF00);
        chk("tap1_valid", out_valid_a, 0);
        chk("tap_switch_occ", occ_a, 1);
        tap_sel_a = 2'd3; in_valid = 1'b0;
        step();

        // Synchronous clear beats ce and blocks the presented sample
        issue(18'h00005, 1'b1, 48'h0000_0000_0005, 48'h0000_0000_0005);
        issue(18'h1ABCD, 1'b1, 48'h0000_0001_ABCD, 48'h0000_0001_ABCD);
        issue(18'h20000, 1'b1, 48'hFFFF_FFFE_0000, 48'h0000_0002_0000);
        chk("pre_sclr_occ", occ_a, 3);
        sclr = 1'b1; ce = 1'b1; in_data = 18'h3FFFF; in_valid = 1'b1;
        step();
        sb.delete();
        sclr = 1'b0; ce = 1'b0; in_valid = 1'b0;
        chk("sclr_occ", occ_a, 0);
        for (int t = 1; t <= 3; t++) begin
            tap_sel_a = 2'(t);
            #1;
            chk("sclr_tap_data", out_data_a, 0);
            chk("sclr_tap_valid", out_valid_a, 0);
        end
        tap_sel_a = 2'd3;

        // Asynchronous reset between edges
        issue(18'h3FFFF, 1'b1, 48'hFFFF_FFFF_FFFF, 48'h0000_0003_FFFF);
        issue(18'h2A5A5, 1'b1, 48'hFFFF_FFFE_A5A5, 48'h0000_0002_A5A5);
        issue(18'h00005, 1'b1, 48'h0000_0000_0005, 48'h0000_0000_0005);
        chk("pre_arst_occ", occ_a, 3);
        ce = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_occ", occ_a, 0);
        chk("arst_valid", out_valid_a, 0);
        chk("arst_data", out_data_a, 0);
        tap_sel_a = 2'd0; in_data = 18'h3FFFF; in_valid = 1'b1;
        #1;
        chk("arst_bypass_data", out_data_a, 48'hFFFF_FFFF_FFFF);
        chk("arst_bypass_valid", out_valid_a, 1);
        sb.delete();
        tap_sel_a = 2'd3; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Out-of-range tap on the DEPTH=2 instance
        tap_sel_c = 2'd3;
        issue(18'h1ABCD, 1'b1, 48'h0000_0001_ABCD, 48'h0000_0001_ABCD);
        issue(18'h2A5A5, 1'b1, 48'hFFFF_FFFE_A5A5, 48'h0000_0002_A5A5);
        ce = 1'b0; in_valid = 1'b0;
        chk("tap_err_c_hi", tap_err_c, 1);
        chk("tap_err_c_data", out_data_c, 18'h1ABCD);
        chk("tap_err_c_valid", out_valid_c, 1);
        chk("tap_err_a_lo", tap_err_a, 0);
        tap_sel_c = 2'd2;
        #1;
        chk("tap2_c_err", tap_err_c, 0);
        chk("tap2_c_data", out_data_c, 18'h1ABCD);
        tap_sel_c = 2'd1;
        #1;
        chk("tap1_c_data", out_data_c, 18'h2A5A5);
        issue(18'h00000, 1'b0, '0, '0);
        issue(18'h00000, 1'b0, '0, '0);
        ce = 1'b0;
        @(negedge clk);
        #1;
        chk("sb_drained2", sb.size(), 0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
